arb_req_agent: RTL

- Requester-side agent for the 4-client synchronous MSB-priority arbiter.
- Accepts per-client transfer jobs, drives the arbiter's req[3:0], and watches its grant[3:0].
- Holds each request for a programmed number of granted cycles, then releases it and reports completion.
- Also flags wait timeouts and grant-protocol violations; sits between client logic and the arbiter.

---
 rtl/arb_req_agent.sv | 112 +++++++++++
 1 files changed

// File: rtl/arb_req_agent.sv
// Requester-side agent for a 4-client MSB-priority arbiter: one small FSM per client
// holds req for a programmed number of granted cycles and watches for timeouts and grant misuse.
module arb_req_agent #(
  parameter int NUM_CLIENTS = 4,
  parameter int LEN_W       = 4,
  parameter int TO_W        = 5,
  parameter int TIMEOUT     = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CLIENTS-1:0]       start,
  input  logic [NUM_CLIENTS*LEN_W-1:0] len,
  input  logic [NUM_CLIENTS-1:0]       grant,
  output logic [NUM_CLIENTS-1:0]       req,
  output logic [NUM_CLIENTS-1:0]       busy,
  output logic [NUM_CLIENTS-1:0]       done,
  output logic [NUM_CLIENTS-1:0]       timeout,
  output logic                         proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10,
    REL  = 2'b11
  } state_t;

  localparam logic [LEN_W-1:0] REM_ONE   = LEN_W'(1);
  localparam logic [TO_W-1:0]  WCNT_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0]  WCNT_LAST = TO_W'(TIMEOUT - 1);

  state_t           state [NUM_CLIENTS];
  logic [LEN_W-1:0] rem   [NUM_CLIENTS];
  logic [TO_W-1:0]  wcnt  [NUM_CLIENTS];
  logic             stray_grant;
  logic             multi_grant;

  assign multi_grant = ($countones(grant) > 1);

  // REL is exempt: the arbiter's registered grant trails our request drop by a cycle.
  always_comb begin
    // NOTE: default assignment first so no path leaves stray_grant unassigned (no latch).
    stray_grant = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant[i] && !req[i] && (state[i] != REL)) stray_grant = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the per-client arrays are a handful of flops, not a RAM, so they reset with the rest.
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        state[i] <= IDLE;
        rem[i]   <= '0;
        wcnt[i]  <= '0;
      end
      req       <= '0;
      busy      <= '0;
      done      <= '0;
      timeout   <= '0;
      proto_err <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every client decides from the same pre-edge state.
      if (multi_grant || stray_grant) proto_err <= 1'b1;

      for (int i = 0; i < NUM_CLIENTS; i++) begin
        done[i]    <= 1'b0;
        timeout[i] <= 1'b0;
        case (state[i])
          IDLE: begin
            if (start[i]) begin
              rem[i]   <= (len[i*LEN_W +: LEN_W] == '0) ? REM_ONE : len[i*LEN_W +: LEN_W];
              wcnt[i]  <= '0;
              state[i] <= WAIT;
              req[i]   <= 1'b1;
              busy[i]  <= 1'b1;
            end
          end
          WAIT, HOLD: begin
            if (grant[i]) begin
              if (rem[i] != '0) rem[i] <= rem[i] - REM_ONE;
              if (rem[i] <= REM_ONE) begin
                state[i] <= REL;
                req[i]   <= 1'b0;
                done[i]  <= 1'b1;
              end else begin
                state[i] <= HOLD;
              end
            end else if (state[i] == HOLD) begin
              // Preempted: go back to waiting with a fresh wait budget.
              state[i] <= WAIT;
              wcnt[i]  <= '0;
            end else if (wcnt[i] == WCNT_LAST) begin
              state[i]   <= IDLE;
              req[i]     <= 1'b0;
              busy[i]    <= 1'b0;
              timeout[i] <= 1'b1;
            end else begin
              wcnt[i] <= wcnt[i] + WCNT_ONE;
            end
          end
          REL: begin
            state[i] <= IDLE;
            busy[i]  <= 1'b0;
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

endmodule
